wb_rr_arbiter: RTL and testbench

- Two-master, one-slave Wishbone round-robin arbiter sharing the SPI Wishbone slave (`top`) between two requesters, e.g. a CPU bus and a DMA/sequencer.
- Sits between the masters and the slave's ADR_I/DAT_I/WE_I/CYC_I/STB_I/DAT_O/ACK_O port set.
- Grants bus ownership per CYC_I cycle, muxes the request path, and routes ACK/data back.
- Optional watchdog aborts a slave that never acknowledges.

---
 rtl/wb_rr_arbiter.sv | 102 ++++++++++
 tb/tb_wb_rr_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master round-robin Wishbone arbiter in front of one slave.
// Optional slave watchdog compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int ADR_W          = 8,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [ADR_W-1:0] M0_ADR_I,
    input  logic [DAT_W-1:0] M0_DAT_I,
    input  logic             M0_WE_I,
    input  logic             M0_CYC_I,
    input  logic             M0_STB_I,
    output logic [DAT_W-1:0] M0_DAT_O,
    output logic             M0_ACK_O,
    output logic             M0_ERR_O,
    input  logic [ADR_W-1:0] M1_ADR_I,
    input  logic [DAT_W-1:0] M1_DAT_I,
    input  logic             M1_WE_I,
    input  logic             M1_CYC_I,
    input  logic             M1_STB_I,
    output logic [DAT_W-1:0] M1_DAT_O,
    output logic             M1_ACK_O,
    output logic             M1_ERR_O,
    output logic [ADR_W-1:0] S_ADR_O,
    output logic [DAT_W-1:0] S_DAT_O,
    output logic             S_WE_O,
    output logic             S_CYC_O,
    output logic             S_STB_O,
    input  logic [DAT_W-1:0] S_DAT_I,
    input  logic             S_ACK_I,
    output logic [1:0]       GNT_O
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state, state_nxt;
    logic       last_grant;
    logic       g0, g1, raw_stb, timeout;

    assign g0 = state == GNT0;
    assign g1 = state == GNT1;

    // next owner: hold while the owner keeps CYC, otherwise arbitrate from IDLE
    always_comb begin
        state_nxt = g0 ? (M0_CYC_I ? GNT0 : IDLE) :
                    g1 ? (M1_CYC_I ? GNT1 : IDLE) :
                    (M0_CYC_I && M1_CYC_I) ? (last_grant ? GNT0 : GNT1) :
                    M0_CYC_I ? GNT0 : M1_CYC_I ? GNT1 : IDLE;
    end

    // grant register and round-robin memory of the last released owner
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (g0 && !M0_CYC_I)
                last_grant <= 1'b0;
            else if (g1 && !M1_CYC_I)
                last_grant <= 1'b1;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt;

    // ACK on the terminal cycle wins over the abort
    assign timeout = raw_stb && !S_ACK_I && stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1);

    // count consecutive unacknowledged strobe cycles of the current owner
    always_ff @(posedge CLK_I) begin
        if (!RST_I || !raw_stb || S_ACK_I || timeout || state_nxt != state)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // request path to the slave and response path back to the owner
    always_comb begin
        raw_stb  = g0 ? (M0_STB_I && M0_CYC_I) : g1 ? (M1_STB_I && M1_CYC_I) : 1'b0;
        S_ADR_O  = g0 ? M0_ADR_I : g1 ? M1_ADR_I : '0;
        S_DAT_O  = g0 ? M0_DAT_I : g1 ? M1_DAT_I : '0;
        S_WE_O   = g0 ? M0_WE_I : g1 ? M1_WE_I : 1'b0;
        S_CYC_O  = g0 ? M0_CYC_I : g1 ? M1_CYC_I : 1'b0;
        S_STB_O  = raw_stb && !timeout;
        M0_ACK_O = g0 && S_ACK_I && S_STB_O;
        M1_ACK_O = g1 && S_ACK_I && S_STB_O;
        M0_DAT_O = g0 ? S_DAT_I : '0;
        M1_DAT_O = g1 ? S_DAT_I : '0;
        M0_ERR_O = g0 && timeout;
        M1_ERR_O = g1 && timeout;
        GNT_O    = {g1, g0};
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: vector table, directed corner sequences and random traffic vs a reference model.
module tb_wb_rr_arbiter;
    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][7:0]  adr;
    logic [1:0][31:0] wdat;
    logic [1:0]       we, cyc, stb;
    logic [31:0]      s_rdat;
    logic             s_ack;
    logic [31:0]      m0_dat, m1_dat, s_dat;
    logic             m0_ack, m1_ack, m0_err, m1_err;
    logic [7:0]       s_adr;
    logic             s_we, s_cyc, s_stb;
    logic [1:0]       gnt;

    int total = 0;
    int bad = 0;

    // reference model: current owner (-1 none), last released owner, stall length
    int own, last, stall;
    logic [1:0]       e_gnt, e_ack, e_err;
    logic [1:0][31:0] e_dat;
    logic [7:0]       e_sadr;
    logic [31:0]      e_sdat;
    logic             e_swe, e_scyc, e_sstb, m_raw, m_to;

    typedef struct {
        logic       rst_n, c0, s0, c1, s1, ack;
        logic [1:0] gnt;
        logic       sstb, a0, a1;
        logic [7:0] sadr;
        logic [31:0] sdat;
    } vec_t;
    vec_t tbl[16];

    wb_rr_arbiter #(.ADR_W(8), .DAT_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_ADR_I(adr[0]), .M0_DAT_I(wdat[0]), .M0_WE_I(we[0]), .M0_CYC_I(cyc[0]), .M0_STB_I(stb[0]),
        .M0_DAT_O(m0_dat), .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err),
        .M1_ADR_I(adr[1]), .M1_DAT_I(wdat[1]), .M1_WE_I(we[1]), .M1_CYC_I(cyc[1]), .M1_STB_I(stb[1]),
        .M1_DAT_O(m1_dat), .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err),
        .S_ADR_O(s_adr), .S_DAT_O(s_dat), .S_WE_O(s_we), .S_CYC_O(s_cyc), .S_STB_O(s_stb),
        .S_DAT_I(s_rdat), .S_ACK_I(s_ack), .GNT_O(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endtask

    task automatic expect_outs();
        e_gnt = 2'b00; e_ack = 2'b00; e_err = 2'b00; e_dat = '0;
        e_sadr = '0; e_sdat = '0; e_swe = 1'b0; e_scyc = 1'b0; e_sstb = 1'b0;
        m_raw = 1'b0; m_to = 1'b0;
        if (own >= 0) begin
            e_gnt = (own == 0) ? 2'b01 : 2'b10;
            e_sadr = adr[own]; e_sdat = wdat[own]; e_swe = we[own]; e_scyc = cyc[own];
            m_raw = stb[own] && cyc[own];
`ifdef WB_ARB_TIMEOUT_EN
            m_to = m_raw && !s_ack && stall == TO - 1;
`endif
            e_sstb = m_raw && !m_to;
            e_ack[own] = s_ack && e_sstb;
            e_dat[own] = s_rdat;
            e_err[own] = m_to;
        end
    endtask

    task automatic model_step();
        int nxt;
        expect_outs();
        if (!rst_n) begin
            own = -1; last = 1; stall = 0;
        end else begin
            nxt = own;
            if (own < 0)
                nxt = (cyc[0] && cyc[1]) ? 1 - last : cyc[0] ? 0 : cyc[1] ? 1 : -1;
            else if (!cyc[own]) begin
                last = own;
                nxt = -1;
            end
            stall = (nxt != own || !m_raw || s_ack || m_to) ? 0 : stall + 1;
            own = nxt;
        end
    endtask

    task automatic check_outs();
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("slave_bus", 64'({s_adr, s_dat, s_we, s_cyc, s_stb}), 64'({e_sadr, e_sdat, e_swe, e_scyc, e_sstb}));
        chk("m0_resp", 64'({m0_dat, m0_ack, m0_err}), 64'({e_dat[0], e_ack[0], e_err[0]}));
        chk("m1_resp", 64'({m1_dat, m1_ack, m1_err}), 64'({e_dat[1], e_ack[1], e_err[1]}));
    endtask

    task automatic pre();
        @(negedge clk);
        expect_outs();
        check_outs();
    endtask

    task automatic post();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic cycle();
        pre();
        post();
    endtask

    initial begin
        own = -1; last = 1; stall = 0;
        rst_n = 1'b0; cyc = '0; stb = '0; we = 2'b01; s_ack = 1'b0;
        adr[0] = 8'h04; adr[1] = 8'h10;
        wdat[0] = 32'hA5A5_0001; wdat[1] = 32'h0000_0BEE; s_rdat = 32'h1234_5678;
        @(posedge clk);
        #1;
        model_step();

        //            rst c0 s0 c1 s1 ack  gnt  sstb a0 a1 sadr   sdat
        tbl[0]  = '{1'b0,0,0,0,0,0, 2'b00, 0,0,0, 8'h00, 32'h0};
        tbl[1]  = '{1'b1,1,1,0,0,0, 2'b00, 0,0,0, 8'h00, 32'h0};
        tbl[2]  = '{1'b1,1,1,0,0,0, 2'b01, 1,0,0, 8'h04, 32'hA5A5_0001};
        tbl[3]  = '{1'b1,1,1,0,0,0, 2'b01, 1,0,0, 8'h04, 32'hA5A5_0001};
        tbl[4]  = '{1'b1,1,1,0,0,1, 2'b01, 1,1,0, 8'h04, 32'hA5A5_0001};
        tbl[5]  = '{1'b1,0,0,0,0,0, 2'b01, 0,0,0, 8'h04, 32'hA5A5_0001};
        tbl[6]  = '{1'b0,0,0,0,0,1, 2'b00, 0,0,0, 8'h00, 32'h0};
        tbl[7]  = '{1'b1,1,1,1,1,0, 2'b00, 0,0,0, 8'h00, 32'h0};
        tbl[8]  = '{1'b1,1,1,1,1,1, 2'b01, 1,1,0, 8'h04, 32'hA5A5_0001};
        tbl[9]  = '{1'b1,0,0,1,1,1, 2'b01, 0,0,0, 8'h04, 32'hA5A5_0001};
        tbl[10] = '{1'b1,0,0,1,1,0, 2'b00, 0,0,0, 8'h00, 32'h0};
        tbl[11] = '{1'b1,0,0,1,1,1, 2'b10, 1,0,1, 8'h10, 32'h0000_0BEE};
        tbl[12] = '{1'b1,0,0,0,0,0, 2'b10, 0,0,0, 8'h10, 32'h0000_0BEE};
        tbl[13] = '{1'b1,1,1,1,1,0, 2'b00, 0,0,0, 8'h00, 32'h0};
        tbl[14] = '{1'b1,0,0,0,0,0, 2'b01, 0,0,0, 8'h04, 32'hA5A5_0001};
        tbl[15] = '{1'b1,0,0,0,0,0, 2'b00, 0,0,0, 8'h00, 32'h0};
        for (int i = 0; i < 16; i++) begin
            rst_n = tbl[i].rst_n; cyc = {tbl[i].c1, tbl[i].c0}; stb = {tbl[i].s1, tbl[i].s0}; s_ack = tbl[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
            chk($sformatf("vec%0d_sstb", i), 64'(s_stb), 64'(tbl[i].sstb));
            chk($sformatf("vec%0d_ack0", i), 64'(m0_ack), 64'(tbl[i].a0));
            chk($sformatf("vec%0d_ack1", i), 64'(m1_ack), 64'(tbl[i].a1));
            chk($sformatf("vec%0d_sadr", i), 64'(s_adr), 64'(tbl[i].sadr));
            chk($sformatf("vec%0d_sdat", i), 64'(s_dat), 64'(tbl[i].sdat));
            post();
        end

        // locked three-beat read by M0 while M1 waits
        rst_n = 1'b0; cyc = '0; stb = '0; s_ack = 1'b0;
        cycle();
        rst_n = 1'b1; cyc = 2'b11; stb = 2'b11; we = 2'b00;
        cycle();
        for (int b = 0; b < 3; b++) begin
            adr[0] = 8'(b * 4); s_ack = 1'b0;
            cycle();
            s_ack = 1'b1;
            pre();
            chk("lock_gnt", 64'(gnt), 64'(2'b01));
            chk("lock_ack0", 64'(m0_ack), 64'(1'b1));
            chk("lock_ack1", 64'(m1_ack), 64'(1'b0));
            chk("lock_adr", 64'(s_adr), 64'(b * 4));
            post();
        end

        // M1 read data routing, then reset with M1's strobe pending
        cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0;
        cycle();
        cycle();
        s_ack = 1'b1; s_rdat = 32'h1234_5678;
        pre();
        chk("m1_rd_dat", 64'(m1_dat), 64'h1234_5678);
        chk("m1_rd_ack", 64'(m1_ack), 64'(1'b1));
        chk("m0_rd_dat", 64'(m0_dat), 64'(0));
        post();
        s_ack = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; cyc = '0; stb = '0; s_ack = 1'b1;
        pre();
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_sstb", 64'({s_stb, s_cyc}), 64'(0));
        chk("rst_late_ack", 64'(m1_ack), 64'(0));
        post();

        // M0 strobes into a slave that never acknowledges
        s_ack = 1'b0; cyc = 2'b01; stb = 2'b01;
        cycle();
        for (int k = 1; k <= 6; k++) begin
            pre();
`ifdef WB_ARB_TIMEOUT_EN
            chk($sformatf("wd_err%0d", k), 64'(m0_err), 64'(k == TO));
            chk($sformatf("wd_stb%0d", k), 64'(s_stb), 64'(k != TO));
`else
            chk($sformatf("wd_err%0d", k), 64'(m0_err), 64'(0));
            chk($sformatf("wd_stb%0d", k), 64'(s_stb), 64'(1));
`endif
            chk($sformatf("wd_ack%0d", k), 64'(m0_ack), 64'(0));
            post();
        end
        cyc = '0; stb = '0;
        cycle();
        cycle();

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst_n = $urandom_range(0, 59) != 0;
            for (int m = 0; m < 2; m++) begin
                cyc[m] = cyc[m] ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
                stb[m] = cyc[m] ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                we[m] = 1'($urandom_range(0, 1));
                adr[m] = 8'($urandom);
                wdat[m] = $urandom;
            end
            s_ack = $urandom_range(0, 2) == 0;
            s_rdat = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
